// File: rtl/vram_arbiter.sv
// VRAM bank arbiter: the VDP owns slot cycles, an auxiliary requester is served on free cycles.
// Optional starvation flag compiled in with `define VRAM_ARB_STARVE_EN.
module vram_arbiter #(
  parameter int STARVE_MAX = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        single_bank,
  input  logic        vdp_slot,
  input  logic [16:0] vdp_addr,
  input  logic        vdp_we,
  input  logic [7:0]  vdp_wdata,
  output logic [15:0] vdp_rdata,
  input  logic        aux_req,
  input  logic        aux_we,
  input  logic [16:0] aux_addr,
  input  logic [7:0]  aux_wdata,
  output logic        aux_ack,
  output logic        aux_done,
  output logic [7:0]  aux_rdata,
  output logic        aux_busy,
  output logic        aux_starved,
  output logic [15:0] ram_addr,
  output logic        ram_we_lo,
  output logic        ram_we_hi,
  output logic [7:0]  ram_d,
  input  logic [7:0]  ram_q_lo,
  input  logic [7:0]  ram_q_hi
);

  typedef enum logic [1:0] {IDLE, PEND, ISSUE, DATA} state_t;

  state_t      state;
  logic        aux_we_q;
  logic [16:0] aux_addr_q;
  logic [7:0]  aux_wdata_q;
  logic        vdp_vld_p1;
  logic [15:0] addr_hold;
  logic        vdp_bank;
  logic        aux_bank;

  assign vdp_bank = vdp_addr[16] & ~single_bank;
  assign aux_bank = aux_addr_q[16] & ~single_bank;
  assign aux_busy = (state != IDLE);

  // RAM port mux: a VDP slot always wins, even over an aux access already in ISSUE
  always_comb begin
    ram_addr  = addr_hold;
    ram_d     = aux_wdata_q;
    ram_we_lo = 1'b0;
    ram_we_hi = 1'b0;
    if (vdp_slot) begin
      ram_addr  = vdp_addr[15:0];
      ram_d     = vdp_wdata;
      ram_we_lo = vdp_we & ~vdp_bank;
      ram_we_hi = vdp_we & vdp_bank;
    end else if (state == ISSUE) begin
      ram_addr  = aux_addr_q[15:0];
      ram_d     = aux_wdata_q;
      ram_we_lo = aux_we_q & ~aux_bank;
      ram_we_hi = aux_we_q & aux_bank;
    end
  end

  always_ff @(posedge clk) begin
    addr_hold <= ram_addr;
  end

  // p1: RAM q is valid the cycle after a VDP slot
  always_ff @(posedge clk) begin
    if (reset) begin
      vdp_vld_p1 <= 1'b0;
      vdp_rdata  <= 16'h0000;
    end else begin
      vdp_vld_p1 <= vdp_slot;
      if (vdp_vld_p1) begin
        vdp_rdata <= {(single_bank ? 8'h00 : ram_q_hi), ram_q_lo};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      aux_ack     <= 1'b0;
      aux_done    <= 1'b0;
      aux_rdata   <= 8'h00;
      aux_we_q    <= 1'b0;
      aux_addr_q  <= 17'h00000;
      aux_wdata_q <= 8'h00;
    end else begin
      aux_ack  <= 1'b0;
      aux_done <= 1'b0;
      case (state)
        IDLE: begin
          if (aux_req) begin
            aux_we_q    <= aux_we;
            aux_addr_q  <= aux_addr;
            aux_wdata_q <= aux_wdata;
            aux_ack     <= 1'b1;
            state       <= PEND;
          end
        end
        PEND: begin
          if (!vdp_slot) state <= ISSUE;
        end
        ISSUE: begin
          if (vdp_slot) begin
            state <= PEND;
          end else if (aux_we_q) begin
            aux_done <= 1'b1;
            state    <= IDLE;
          end else begin
            state <= DATA;
          end
        end
        DATA: begin
          aux_rdata <= aux_bank ? ram_q_hi : ram_q_lo;
          aux_done  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VRAM_ARB_STARVE_EN
  localparam logic [8:0] STARVE_LIM = 9'(STARVE_MAX);

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  logic [7:0] starve_cnt;
  logic [7:0] starve_nxt;
  logic       starved_q;

  assign starve_nxt  = sat_inc(starve_cnt);
  assign aux_starved = starved_q;

  // Counts only cycles the VDP actually took from a waiting aux request
  always_ff @(posedge clk) begin
    if (reset || state == IDLE) begin
      starve_cnt <= 8'h00;
      starved_q  <= 1'b0;
    end else if (vdp_slot && (state == PEND || state == ISSUE)) begin
      starve_cnt <= starve_nxt;
      if ({1'b0, starve_nxt} >= STARVE_LIM) starved_q <= 1'b1;
    end
  end
`else
  assign aux_starved = 1'b0;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a two-bank spram model and a read-data scoreboard.
module tb_vram_arbiter;

`ifdef VRAM_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        single_bank;
  logic        vdp_slot;
  logic [16:0] vdp_addr;
  logic        vdp_we;
  logic [7:0]  vdp_wdata;
  logic [15:0] vdp_rdata;
  logic        aux_req;
  logic        aux_we;
  logic [16:0] aux_addr;
  logic [7:0]  aux_wdata;
  logic        aux_ack;
  logic        aux_done;
  logic [7:0]  aux_rdata;
  logic        aux_busy;
  logic        aux_starved;
  logic [15:0] ram_addr;
  logic        ram_we_lo;
  logic        ram_we_hi;
  logic [7:0]  ram_d;
  logic [7:0]  ram_q_lo;
  logic [7:0]  ram_q_hi;

  vram_arbiter #(.STARVE_MAX(255)) dut (
    .clk(clk), .reset(reset), .single_bank(single_bank),
    .vdp_slot(vdp_slot), .vdp_addr(vdp_addr), .vdp_we(vdp_we),
    .vdp_wdata(vdp_wdata), .vdp_rdata(vdp_rdata),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr),
    .aux_wdata(aux_wdata), .aux_ack(aux_ack), .aux_done(aux_done),
    .aux_rdata(aux_rdata), .aux_busy(aux_busy), .aux_starved(aux_starved),
    .ram_addr(ram_addr), .ram_we_lo(ram_we_lo), .ram_we_hi(ram_we_hi),
    .ram_d(ram_d), .ram_q_lo(ram_q_lo), .ram_q_hi(ram_q_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle-latency spram pair
  logic [7:0] mem_lo [0:65535];
  logic [7:0] mem_hi [0:65535];
  always @(posedge clk) begin
    if (ram_we_lo) mem_lo[ram_addr] <= ram_d;
    if (ram_we_hi) mem_hi[ram_addr] <= ram_d;
    ram_q_lo <= mem_lo[ram_addr];
    ram_q_hi <= mem_hi[ram_addr];
  end

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_mem [logic [16:0]];
  logic [7:0] sb [$];
  bit         slot_q [$];
  bit         lo_hit, hi_hit, blk_flag, starve_chk;
  int         blk_n, last_chk_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] ref_key(input logic [16:0] a);
    return {a[16] & ~single_bank, a[15:0]};
  endfunction

  function automatic logic [7:0] ref_rd(input logic [16:0] a);
    logic [16:0] k;
    k = ref_key(a);
    return ref_mem.exists(k) ? ref_mem[k] : 8'h00;
  endfunction

  task automatic ref_wr(input logic [16:0] a, input logic [7:0] d);
    ref_mem[ref_key(a)] = d;
  endtask

  // One clock: apply the next scheduled vdp_slot value and watch the RAM port
  task automatic cyc();
    @(posedge clk); #1;
    if (blk_flag) blk_n++;
    vdp_slot = (slot_q.size() != 0) ? slot_q.pop_front() : 1'b0;
    #1;
    blk_flag = vdp_slot && aux_busy;
    if (ram_we_lo && ram_addr == 16'hABCD) lo_hit = 1'b1;
    if (ram_we_hi) hi_hit = 1'b1;
    if (vdp_slot)
      chk("slot_owner", {15'd0, ram_we_lo | ram_we_hi, ram_addr}, {16'd0, vdp_addr[15:0]});
    if (starve_chk && blk_n != last_chk_n && (blk_n == 254 || blk_n == 255)) begin
      last_chk_n = blk_n;
      chk($sformatf("starved_at_%0d", blk_n), aux_starved, STARVE_EN && blk_n >= 255);
    end
  endtask

  task automatic aux_op(input string tag, input logic we, input logic [16:0] addr,
                        input logic [7:0] wd, input int exp_lat);
    int n;
    logic got;
    logic [7:0] e;
    aux_we = we; aux_addr = addr; aux_wdata = wd; aux_req = 1'b1;
    if (!we) sb.push_back(ref_rd(addr));
    n = 0; got = 1'b0;
    while (!got && n < 20) begin cyc(); n++; got = aux_ack; end
    chk({tag, "_ack"}, got, 1);
    chk({tag, "_acklat"}, n, 1);
    aux_req = 1'b0;
    got = 1'b0;
    while (!got && n < 600) begin cyc(); n++; got = aux_done; end
    chk({tag, "_done"}, got, 1);
    if (exp_lat > 0) chk({tag, "_lat"}, n, exp_lat);
    if (we) begin
      if (got) ref_wr(addr, wd);
    end else if (sb.size() != 0) begin
      e = sb.pop_front();
      if (got) chk({tag, "_rdata"}, aux_rdata, e);
    end
  endtask

  task automatic vdp_read(input logic [16:0] addr);
    @(posedge clk); #1;
    vdp_slot = 1'b1; vdp_we = 1'b0; vdp_addr = addr;
    @(posedge clk); #1;
    vdp_slot = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; single_bank = 1'b0; vdp_slot = 1'b0; vdp_addr = '0;
    vdp_we = 1'b0; vdp_wdata = '0; aux_req = 1'b1; aux_we = 1'b1;
    aux_addr = 17'h00010; aux_wdata = 8'h11;
    lo_hit = 0; hi_hit = 0; blk_flag = 0; starve_chk = 0; blk_n = 0; last_chk_n = -1;

    // Reset held with a request pending
    repeat (3) cyc();
    chk("rst_vdp_rdata", vdp_rdata, 0);
    chk("rst_aux_rdata", aux_rdata, 0);
    chk("rst_aux_ack", aux_ack, 0);
    chk("rst_aux_done", aux_done, 0);
    chk("rst_aux_busy", aux_busy, 0);
    chk("rst_aux_starved", aux_starved, 0);
    reset = 1'b0;
    aux_op("rst_rel_wr", 1'b1, 17'h00010, 8'h11, 3);
    aux_op("rd_10", 1'b0, 17'h00010, 8'h00, 4);

    // VDP write then read in slots
    @(posedge clk); #1;
    vdp_slot = 1'b1; vdp_we = 1'b1; vdp_addr = 17'h01234; vdp_wdata = 8'h5A; #1;
    chk("vdp_wr_we_lo", ram_we_lo, 1);
    chk("vdp_wr_we_hi", ram_we_hi, 0);
    chk("vdp_wr_addr", ram_addr, 16'h1234);
    chk("vdp_wr_d", ram_d, 8'h5A);
    ref_wr(17'h01234, 8'h5A);
    @(posedge clk); #1;
    vdp_we = 1'b0; #1;
    chk("vdp_rd_we_hi", ram_we_hi, 0);
    @(posedge clk); #1;
    vdp_slot = 1'b0;
    @(posedge clk); #1;
    chk("vdp_rdata_lo", vdp_rdata[7:0], ref_rd(17'h01234));

    // Single-bank mode: bit 16 ignored, hi bank never written
    single_bank = 1'b1; lo_hit = 0; hi_hit = 0;
    aux_op("sb_wr", 1'b1, 17'h1ABCD, 8'hC3, 3);
    chk("sb_wr_lo_pulse", lo_hit, 1);
    aux_op("sb_rd", 1'b0, 17'h0ABCD, 8'h00, 4);
    chk("sb_no_hi_we", hi_hit, 0);
    vdp_read(17'h11234);
    chk("sb_vdp_rdata", vdp_rdata, {8'h00, ref_rd(17'h11234)});

    // Full mode hi bank
    single_bank = 1'b0; hi_hit = 0;
    aux_op("hi_wr", 1'b1, 17'h10055, 8'h77, 3);
    chk("hi_we_seen", hi_hit, 1);
    aux_op("hi_rd", 1'b0, 17'h10055, 8'h00, 4);
    vdp_read(17'h00055);
    chk("vdp_rdata_hi", vdp_rdata[15:8], ref_rd(17'h10055));

    // Aux read interleaved with alternating VDP slots
    slot_q = '{1'b1, 1'b0, 1'b1, 1'b0};
    aux_op("alt_rd", 1'b0, 17'h0ABCD, 8'h00, 0);
    chk("alt_vdp_rdata_hi", vdp_rdata[15:8], ref_rd(17'h10055));

    // VDP holds the RAM for 300 cycles
    blk_n = 0; blk_flag = 0; last_chk_n = -1; starve_chk = 1;
    for (int i = 0; i < 300; i++) slot_q.push_back(1'b1);
    aux_op("starve_rd", 1'b0, 17'h10055, 8'h00, 0);
    chk("starve_blocked_cycles", blk_n >= 300, 1);
    starve_chk = 0;
    cyc();
    chk("starved_cleared", aux_starved, 0);

    // Reset during DATA aborts the read
    aux_we = 1'b0; aux_addr = 17'h10055; aux_req = 1'b1;
    cyc();
    chk("rd_abort_ack", aux_ack, 1);
    aux_req = 1'b0;
    cyc();
    cyc();
    chk("rd_abort_in_data", aux_busy, 1);
    chk("rd_abort_no_early_done", aux_done, 0);
    reset = 1'b1;
    cyc();
    chk("rd_abort_done", aux_done, 0);
    chk("rd_abort_rdata", aux_rdata, 0);
    chk("rd_abort_busy", aux_busy, 0);
    reset = 1'b0;
    cyc();
    chk("rd_abort_done_after", aux_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
